// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-captures completed frames into a circular FIFO
// and presents them first-word-fall-through. Optional macro RX_FIFO_ERR_DROP_EN drops errored frames.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_start_err,
    input  logic              rx_stop_err,
    input  logic              rx_data_err,
    input  logic              rd_ready,
    input  logic              ovf_clr,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic [2:0]        rd_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic [7:0]        err_drop_cnt
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_TH);

`ifdef RX_FIFO_ERR_DROP_EN
    localparam int ENTRY_W = 8;
`else
    localparam int ENTRY_W = 11;
`endif

    logic                done_q, done_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic                wr_req, err_frame, wr_cand, wr_en, rd_fire, ovf_evt, drop_evt;
    logic [ENTRY_W-1:0]  entry;
    logic [ENTRY_W-1:0]  head;

    assign wr_req    = rx_done & ~done_q;
    assign err_frame = rx_start_err | rx_stop_err | rx_data_err;

`ifdef RX_FIFO_ERR_DROP_EN
    assign entry    = rx_data;
    assign drop_evt = wr_req & err_frame;
`else
    assign entry    = {rx_start_err, rx_stop_err, rx_data_err, rx_data};
    assign drop_evt = 1'b0;
`endif

    assign wr_cand  = wr_req & ~drop_evt;
    assign full     = (count_q == DEPTH_C);
    assign rd_valid = (count_q != '0);
    assign rd_fire  = rd_valid & rd_ready;
    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign wr_en    = wr_cand & (~full | rd_fire);
    assign ovf_evt  = wr_cand & full & ~rd_fire;

    always_comb begin
        done_d     = rx_done;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_en)   wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (wr_en && !rd_fire)      count_d = count_q + (ADDR_W+1)'(1);
        else if (rd_fire && !wr_en) count_d = count_q - (ADDR_W+1)'(1);
        // A new loss outranks a clear in the same cycle.
        if (ovf_evt)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
        if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= entry;
    end

    // Head is masked while empty so stale memory never shows on the outputs.
    assign head = rd_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        rd_data = head[7:0];
`ifdef RX_FIFO_ERR_DROP_EN
        rd_err  = 3'b000;
`else
        rd_err  = head[10:8];
`endif
    end

    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_C);
    assign overflow    = overflow_q;

`ifdef RX_FIFO_ERR_DROP_EN
    assign err_drop_cnt = drop_cnt_q;
`else
    assign err_drop_cnt = 8'd0;
`endif

endmodule
